// File: rtl/irq_prio_ctrl_pkg.sv
// Shared constants and FSM state encoding for the interrupt priority controller.
package irq_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;
endpackage

// File: rtl/irq_prio_ctrl_enc.sv
// 8-input highest-index priority encoder; bit 7 wins. Zero input gives idx=0, any=0.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        any = |vec;
    end
endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt request controller: sync, pending capture, masking, and a
// valid/ready offer of the highest pending index held until end-of-interrupt.
module irq_prio_ctrl #(
    parameter int N_REQ       = 8,
    parameter bit EDGE_MODE   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          mask,
    output logic                      irq_valid,
    output logic [irq_pkg::IDX_W-1:0] irq_idx,
    input  logic                      irq_ready,
    input  logic                      eoi,
    output logic                      busy,
    output logic [N_REQ-1:0]          pending
);
    import irq_pkg::*;

    logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q;
    logic [N_REQ-1:0]                  req_s;
    logic [N_REQ-1:0]                  req_prev;
    logic [N_REQ-1:0]                  set_v;
    logic [N_REQ-1:0]                  clr_v;
    logic [N_REQ-1:0]                  cand;
    logic [IDX_W-1:0]                  enc_idx;
    logic                              enc_any;
    logic                              accept;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Request synchroniser: stage 0 samples the raw pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            req_prev <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], req};
            req_prev <= req_s;
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_MODE) begin : g_edge
            assign set_v = req_s & ~req_prev;
        end else begin : g_level
            assign set_v = req_s;
        end
    endgenerate

    assign accept = (state_q == OFFER) && irq_ready;
    assign clr_v  = accept ? (N_REQ'(1) << idx_q) : '0;

    // Set is applied after clear so a same-cycle new event is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~clr_v) | set_v;
    end

    assign cand = pending & mask;

    prio_enc8 u_enc (
        .vec (cand),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The index is latched on entry to OFFER and held through SERVICE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_d = OFFER;
                    idx_d   = enc_idx;
                end
            end
            OFFER: begin
                if (irq_ready) state_d = SERVICE;
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_valid = (state_q == OFFER);
    assign busy      = (state_q == SERVICE);
    assign irq_idx   = idx_q;
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: edge-mode vector table plus hand sequences
// for level mode and asynchronous reset.
module tb_irq_prio_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0, mask = '0;
    logic       rdy = 1'b0, eoi = 1'b0;
    logic       vld, bsy;
    logic [2:0] idx;
    logic [7:0] pend;

    logic [7:0] req2 = '0, mask2 = '0;
    logic       rdy2 = 1'b0, eoi2 = 1'b0;
    logic       vld2, bsy2;
    logic [2:0] idx2;
    logic [7:0] pend2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_prio_ctrl #(.EDGE_MODE(1'b1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .irq_valid(vld), .irq_idx(idx), .irq_ready(rdy),
        .eoi(eoi), .busy(bsy), .pending(pend)
    );

    irq_prio_ctrl #(.EDGE_MODE(1'b0), .SYNC_STAGES(2)) dut_lvl (
        .clk(clk), .rst(rst), .req(req2), .mask(mask2),
        .irq_valid(vld2), .irq_idx(idx2), .irq_ready(rdy2),
        .eoi(eoi2), .busy(bsy2), .pending(pend2)
    );

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       rdy;
        logic       eoi;
        logic       vld;
        logic [2:0] idx;
        logic       bsy;
        logic [7:0] pend;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [7:0] r, input logic [7:0] m, input logic rd,
                       input logic e, input logic v, input logic [2:0] ix,
                       input logic b, input logic [7:0] p);
        vec_t t;
        t.req = r; t.mask = m; t.rdy = rd; t.eoi = e;
        t.vld = v; t.idx = ix; t.bsy = b; t.pend = p;
        tv.push_back(t);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Pulse req[5]; ready ignored in IDLE
        add(8'h20, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        add(8'h00, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        add(8'h00, 8'hFF, 0, 0, 0, 0, 0, 8'h20);
        add(8'h00, 8'hFF, 0, 0, 1, 5, 0, 8'h20);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 1, 8'h00);
        add(8'h00, 8'hFF, 0, 0, 0, 0, 1, 8'h00);
        add(8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'h00);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 0, 8'h00);
        // req[2]+req[6], then req[7] mid-offer: no preemption; eoi in OFFER ignored
        add(8'h44, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        add(8'h44, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        add(8'h44, 8'hFF, 0, 0, 0, 0, 0, 8'h44);
        add(8'hC4, 8'hFF, 0, 0, 1, 6, 0, 8'h44);
        add(8'hC4, 8'hFF, 0, 1, 1, 6, 0, 8'h44);
        add(8'hC4, 8'hFF, 0, 0, 1, 6, 0, 8'hC4);
        add(8'hC4, 8'hFF, 1, 0, 0, 0, 1, 8'h84);
        add(8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'h84);
        add(8'h00, 8'hFF, 0, 0, 1, 7, 0, 8'h84);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 1, 8'h04);
        add(8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'h04);
        add(8'h00, 8'hFF, 0, 0, 1, 2, 0, 8'h04);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 1, 8'h00);
        add(8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'h00);
        // Masked bit 7 stays pending; unmask during offer does not retract
        add(8'h81, 8'h7F, 0, 0, 0, 0, 0, 8'h00);
        add(8'h00, 8'h7F, 0, 0, 0, 0, 0, 8'h00);
        add(8'h00, 8'h7F, 0, 0, 0, 0, 0, 8'h81);
        add(8'h00, 8'h7F, 0, 0, 1, 0, 0, 8'h81);
        add(8'h00, 8'hFF, 0, 0, 1, 0, 0, 8'h81);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 1, 8'h80);
        add(8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'h80);
        add(8'h00, 8'hFF, 0, 0, 1, 7, 0, 8'h80);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 1, 8'h00);
        add(8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'h00);
        // New req[3] edge lands on the accept edge: set wins
        add(8'h08, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        add(8'h00, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        add(8'h08, 8'hFF, 0, 0, 0, 0, 0, 8'h08);
        add(8'h08, 8'hFF, 0, 0, 1, 3, 0, 8'h08);
        add(8'h08, 8'hFF, 1, 0, 0, 0, 1, 8'h08);
        add(8'h08, 8'hFF, 0, 1, 0, 0, 0, 8'h08);
        add(8'h08, 8'hFF, 0, 0, 1, 3, 0, 8'h08);
        add(8'h00, 8'hFF, 1, 0, 0, 0, 1, 8'h00);
        add(8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'h00);

        // Reset state
        #12;
        check("rst_vld", {7'd0, vld}, 8'h00);
        check("rst_idx", {5'd0, idx}, 8'h00);
        check("rst_bsy", {7'd0, bsy}, 8'h00);
        check("rst_pend", pend, 8'h00);
        check("rst_pend_lvl", pend2, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            req = tv[i].req; mask = tv[i].mask; rdy = tv[i].rdy; eoi = tv[i].eoi;
            tick();
            check($sformatf("v%0d_vld", i), {7'd0, vld}, {7'd0, tv[i].vld});
            check($sformatf("v%0d_bsy", i), {7'd0, bsy}, {7'd0, tv[i].bsy});
            check($sformatf("v%0d_pend", i), pend, tv[i].pend);
            if (tv[i].vld)
                check($sformatf("v%0d_idx", i), {5'd0, idx}, {5'd0, tv[i].idx});
        end
        req = '0; rdy = 1'b0; eoi = 1'b0;

        // Level mode: held req[4] re-offered straight after eoi
        req2 = 8'h10; mask2 = 8'hFF;
        repeat (3) tick();
        check("lvl_pend", pend2, 8'h10);
        check("lvl_vld_early", {7'd0, vld2}, 8'h00);
        tick();
        check("lvl_vld", {7'd0, vld2}, 8'h01);
        check("lvl_idx", {5'd0, idx2}, 8'h04);
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
        check("lvl_acc_bsy", {7'd0, bsy2}, 8'h01);
        check("lvl_acc_vld", {7'd0, vld2}, 8'h00);
        tick();
        check("lvl_repend", pend2, 8'h10);
        eoi2 = 1'b1;
        tick();
        eoi2 = 1'b0;
        check("lvl_eoi_bsy", {7'd0, bsy2}, 8'h00);
        tick();
        check("lvl_b2b_vld", {7'd0, vld2}, 8'h01);
        check("lvl_b2b_idx", {5'd0, idx2}, 8'h04);

        // Async reset mid-SERVICE with pending=F0
        req = 8'h02; mask = 8'hFF;
        tick();
        req = 8'h00;
        repeat (2) tick();
        check("ar_pend1", pend, 8'h02);
        tick();
        check("ar_idx1", {5'd0, idx}, 8'h01);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        req = 8'hF0;
        repeat (3) tick();
        req = 8'h00;
        check("ar_pre_bsy", {7'd0, bsy}, 8'h01);
        check("ar_pre_pend", pend, 8'hF0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_bsy", {7'd0, bsy}, 8'h00);
        check("ar_vld", {7'd0, vld}, 8'h00);
        check("ar_idx", {5'd0, idx}, 8'h00);
        check("ar_pend", pend, 8'h00);
        check("ar_lvl_vld", {7'd0, vld2}, 8'h00);
        req2 = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) tick();
        check("ar_no_offer", {7'd0, vld}, 8'h00);
        check("ar_no_pend", pend, 8'h00);
        check("ar_lvl_no_pend", pend2, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
